// File: rtl/phs_seq_pkg.sv
// Shared definitions for the MMCM fine-phase step sequencer: state encodings,
// default widths and the target clamp.
package phs_seq_pkg;

    localparam int PHS_PW        = 10;
    localparam int PHS_MAX_PHASE = 511;

    // Encodings are visible on the status readback port, so values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_W4LOCK = 3'd1,
        ST_READY  = 3'd2,
        ST_STEP   = 3'd3,
        ST_W4DONE = 3'd4,
        ST_SETTLE = 3'd5,
        ST_ERR    = 3'd6
    } seq_state_t;

    function automatic int clamp_phase(input int value, input int max_phase);
        if (value > max_phase) return max_phase;
        if (value < -max_phase) return -max_phase;
        return value;
    endfunction

endpackage

// File: rtl/phs_step_timer.sv
// Loadable down-counter shared by the PS_DONE timeout and the post-step settle wait.
// Load has priority over decrement; the count holds at zero.
module phs_step_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] count;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/phase_step_sequencer.sv
// Closed-loop MMCM fine-phase controller: issues single PSEN steps toward a clamped
// goal, waits for PS_DONE between steps, and restarts from phase 0 on every relock.
module phase_step_sequencer
    import phs_seq_pkg::*;
#(
    parameter int PW            = PHS_PW,
    parameter int MAX_PHASE     = PHS_MAX_PHASE,
    parameter int TO_CYCLES     = 1023,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 locked,
    input  logic                 load,
    input  logic signed [PW-1:0] target,
    input  logic                 ps_done,
    output logic                 psen,
    output logic                 psincdec,
    output logic signed [PW-1:0] cur_phase,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err,
    output logic [2:0]           seq_state
);
    localparam int TIMER_MAX = (TO_CYCLES > SETTLE_CYCLES) ? TO_CYCLES : SETTLE_CYCLES;
    localparam int TW        = $clog2(TIMER_MAX + 1);
    localparam logic [TW-1:0] TO_LOAD     = TW'(TO_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic signed [PW-1:0] ONE  = PW'(1);

    seq_state_t           state;
    logic signed [PW-1:0] goal;
    logic signed [PW-1:0] goal_next;
    logic signed [PW-1:0] target_clamped;
    logic signed [PW-1:0] cur_stepped;
    logic                 timer_load;
    logic                 timer_dec;
    logic                 timer_zero;
    logic [TW-1:0]        timer_value;

    assign target_clamped = PW'(clamp_phase(int'(target), MAX_PHASE));
    // A LOAD in the current cycle is already visible to decisions taken this cycle.
    assign goal_next      = load ? target_clamped : goal;
    assign cur_stepped    = psincdec ? cur_phase + ONE : cur_phase - ONE;
    assign seq_state      = state;

    // Timer is armed with the timeout in STEP and re-armed with the settle time on PS_DONE.
    assign timer_load  = (state == ST_STEP) || (state == ST_W4DONE && ps_done);
    assign timer_value = (state == ST_STEP) ? TO_LOAD : SETTLE_LOAD;
    assign timer_dec   = (state == ST_W4DONE) || (state == ST_SETTLE);

    phs_step_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (timer_value),
        .dec        (timer_dec),
        .zero       (timer_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            goal        <= '0;
            cur_phase   <= '0;
            psen        <= 1'b0;
            psincdec    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each cycle; only the branches that pulse them set 1.
            psen <= 1'b0;
            done <= 1'b0;
            if (load) goal <= target_clamped;

            if (!locked && state != ST_IDLE) begin
                state       <= ST_W4LOCK;
                cur_phase   <= '0;
                psincdec    <= 1'b0;
                busy        <= 1'b0;
                timeout_err <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_W4LOCK;
                    ST_W4LOCK: begin
                        state <= ST_READY;
                        busy  <= (goal_next != cur_phase);
                    end
                    ST_READY: begin
                        if (goal_next != cur_phase) begin
                            state    <= ST_STEP;
                            psen     <= 1'b1;
                            psincdec <= (goal_next > cur_phase);
                            busy     <= 1'b1;
                        end else begin
                            busy <= 1'b0;
                            done <= load;
                        end
                    end
                    ST_STEP: state <= ST_W4DONE;
                    ST_W4DONE: begin
                        if (ps_done) begin
                            cur_phase <= cur_stepped;
                            psincdec  <= 1'b0;
                            done      <= (cur_stepped == goal_next);
                            if (SETTLE_CYCLES == 0) begin
                                state <= ST_READY;
                                busy  <= (goal_next != cur_stepped);
                            end else begin
                                state <= ST_SETTLE;
                            end
                        end else if (timer_zero) begin
                            state       <= ST_ERR;
                            psincdec    <= 1'b0;
                            busy        <= 1'b0;
                            timeout_err <= 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        if (timer_zero) begin
                            state <= ST_READY;
                            busy  <= (goal_next != cur_phase);
                        end
                    end
                    ST_ERR: begin
                        if (load) begin
                            state       <= ST_READY;
                            timeout_err <= 1'b0;
                            busy        <= (goal_next != cur_phase);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_phase_step_sequencer.sv
// Self-checking bench: emulates the MMCM PS port with random PS_DONE latency and
// checks the sequencer against a position/goal model of the stepping rules.
module tb_phase_step_sequencer;

    localparam int PW     = 11;
    localparam int MAXP   = 511;
    localparam int TO     = 1023;
    localparam int SETTLE = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 locked;
    logic                 load;
    logic signed [PW-1:0] target;
    logic                 ps_done;
    logic                 psen;
    logic                 psincdec;
    logic signed [PW-1:0] cur_phase;
    logic                 busy;
    logic                 done;
    logic                 timeout_err;
    logic [2:0]           seq_state;

    phase_step_sequencer #(
        .PW(PW), .MAX_PHASE(MAXP), .TO_CYCLES(TO), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .locked      (locked),
        .load        (load),
        .target      (target),
        .ps_done     (ps_done),
        .psen        (psen),
        .psincdec    (psincdec),
        .cur_phase   (cur_phase),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .seq_state   (seq_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_psen_cyc = -1;
    int n_psen = 0;
    int n_done = 0;
    int model_pos = 0;
    int model_goal = 0;
    int pend_wait = 0;
    int lod_target = 0;
    int drop_pos = 0;
    bit pending = 0;
    bit pend_dir = 0;
    bit deliver = 0;
    bit mute = 0;
    bit lod_armed = 0;
    bit drop_armed = 0;

    task automatic check(input string tag, input logic signed [31:0] observed,
                         input logic signed [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int clampv(input int v);
        if (v > MAXP) return MAXP;
        if (v < -MAXP) return -MAXP;
        return v;
    endfunction

    function automatic bit exp_busy(input logic [2:0] s);
        return (s == 3'd3) || (s == 3'd4) || (s == 3'd5) ||
               (s == 3'd2 && model_pos != model_goal);
    endfunction

    task automatic do_load(input int t);
        load       = 1'b1;
        target     = PW'(t);
        model_goal = clampv(t);
    endtask

    // One clock: apply the edge, update the model, check, then drive the MMCM side.
    task automatic cycle();
        bit del_now;
        bit lock_now;
        del_now  = deliver;
        lock_now = locked;
        @(posedge clk);
        #1;
        cyc++;
        load    = 1'b0;
        ps_done = 1'b0;
        deliver = 1'b0;
        if (!lock_now) begin
            model_pos = 0;
            pending   = 0;
        end else if (del_now) begin
            model_pos = model_pos + (pend_dir ? 1 : -1);
        end

        check("cur_phase", cur_phase, model_pos);
        check("busy", busy, exp_busy(seq_state));
        if (psen) begin
            n_psen++;
            check("psincdec", psincdec, model_goal > model_pos);
            if (last_psen_cyc >= 0)
                check("psen_gap_ok", (cyc - last_psen_cyc) >= SETTLE + 2, 1);
            last_psen_cyc = cyc;
            pending   = 1;
            pend_dir  = psincdec;
            pend_wait = $urandom_range(1, 5);
        end
        if (done) begin
            n_done++;
            check("done_at_goal", cur_phase, model_goal);
        end

        if (drop_armed && pending && model_pos == drop_pos && seq_state == 3'd4) begin
            locked     = 1'b0;
            pending    = 0;
            drop_armed = 0;
        end
        if (pending && !mute) begin
            if (pend_wait == 0) begin
                ps_done = 1'b1;
                deliver = 1'b1;
                pending = 0;
                if (lod_armed) begin
                    do_load(lod_target);
                    lod_armed = 0;
                end
            end else begin
                pend_wait--;
            end
        end
    endtask

    task automatic run_until_idle(input int budget);
        bit reached;
        reached = 0;
        for (int k = 0; k < budget; k++) begin
            cycle();
            if (seq_state == 3'd2 && !busy && !pending) begin
                reached = 1;
                break;
            end
        end
        check("idle_reached", reached, 1);
    endtask

    task automatic seq_to(input string tag, input int t, input int budget);
        int d;
        d = clampv(t) - model_pos;
        if (d < 0) d = -d;
        n_psen = 0;
        n_done = 0;
        do_load(t);
        run_until_idle(budget);
        check({tag, "_pos"}, cur_phase, clampv(t));
        check({tag, "_steps"}, n_psen, d);
        check({tag, "_done"}, n_done, 1);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int w4;
        int k;
        rst_n   = 1'b0;
        locked  = 1'b1;
        load    = 1'b0;
        target  = '0;
        ps_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_psen", psen, 0);
        check("rst_psincdec", psincdec, 0);
        check("rst_cur_phase", cur_phase, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_seq_state", seq_state, 0);
        rst_n = 1'b1;
        cycle();
        check("boot_w4lock", seq_state, 1);
        cycle();
        check("boot_ready", seq_state, 2);

        seq_to("up3", 3, 200);
        seq_to("down_m2", -2, 300);

        // Stray PS_DONE while idle must not move the position.
        ps_done = 1'b1;
        cycle();
        check("spurious_state", seq_state, 2);
        cycle();
        check("spurious_pos", cur_phase, -2);

        // Retarget to +2 on the very cycle the first step's PS_DONE arrives.
        lod_armed  = 1;
        lod_target = 2;
        n_psen = 0;
        n_done = 0;
        do_load(0);
        run_until_idle(300);
        check("lod_pos", cur_phase, 2);
        check("lod_steps", n_psen, 4);
        check("lod_done", n_done, 1);

        // LOAD equal to the current position: DONE one cycle later, no step.
        n_psen = 0;
        do_load(2);
        cycle();
        check("eq_done_pulse", done, 1);
        check("eq_busy", busy, 0);
        check("eq_state", seq_state, 2);
        cycle();
        check("eq_done_clear", done, 0);
        check("eq_no_step", n_psen, 0);

        // Withhold PS_DONE: ERR after exactly TO cycles in W4DONE.
        mute   = 1;
        n_psen = 0;
        w4     = 0;
        do_load(4);
        k = 0;
        while (seq_state != 3'd6 && k < 1200) begin
            cycle();
            if (seq_state == 3'd4) w4++;
            k++;
        end
        check("to_w4done_cycles", w4, TO);
        check("to_state", seq_state, 6);
        check("to_err", timeout_err, 1);
        check("to_one_step", n_psen, 1);
        pending = 0;
        n_psen  = 0;
        repeat (40) cycle();
        check("to_no_psen", n_psen, 0);
        check("to_err_sticky", timeout_err, 1);
        mute = 0;
        do_load(0);
        cycle();
        check("to_err_cleared", timeout_err, 0);
        run_until_idle(300);
        check("to_recover_pos", cur_phase, 0);

        // Lose lock while waiting for PS_DONE at position 2 with goal 5.
        drop_armed = 1;
        drop_pos   = 2;
        do_load(5);
        k = 0;
        while (locked && k < 300) begin
            cycle();
            k++;
        end
        check("drop_happened", locked, 0);
        repeat (5) cycle();
        check("drop_state", seq_state, 1);
        check("drop_pos", cur_phase, 0);
        check("drop_psen", psen, 0);
        locked = 1'b1;
        n_psen = 0;
        n_done = 0;
        run_until_idle(300);
        check("relock_pos", cur_phase, 5);
        check("relock_steps", n_psen, 5);
        check("relock_done", n_done, 1);

        for (int i = 0; i < 6; i++)
            seq_to("rand", int'($urandom_range(0, 60)) - 30, 1000);

        seq_to("clamp_hi", 600, 8000);
        seq_to("clamp_lo", -1000, 15000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
